// File: rtl/bcd_scan_counter.sv
// -----------------------------------------------------------------------------
// bcd_scan_counter
//
// Multi-digit BCD counter with a time-multiplexed, active-low 7-segment driver.
// A prescaler divides the board clock down to the count rate. Each tick steps
// the N-digit BCD value up or down, with the carry or borrow rippling through
// the digits. A separate scan divider walks the anode select across the digits.
//
// Parameters
//   CLK_HZ    input clock frequency in Hz
//   TICK_HZ   count rate in Hz (CLK_HZ/TICK_HZ must be an integer >= 2)
//   DIGITS    number of BCD digits / anodes, 1..8
//   SCAN_DIV  clk cycles each digit stays active while scanning, >= 1
//
// Ports
//   clk       system clock, all state on the rising edge
//   clr       asynchronous active-low reset
//   en        1 = prescaler and count run, 0 = both frozen
//   up_dn     1 = count up, 0 = count down (sampled in the tick cycle)
//   load      synchronous load strobe, has priority over a coincident tick
//   load_val  BCD load value, nibble 0 = least-significant digit
//   count     current BCD value (registered)
//   tick      one-cycle pulse while the prescaler sits at its terminal value
//   wrap      one-cycle pulse when the whole value rolls over (up or down)
//   seg       {a,b,c,d,e,f,g}, active-low
//   an        one-hot active-low anode select, bit 0 = least-significant digit
//
// Optional build macro
//   LEADING_ZERO_BLANK_EN  when defined, leading zero digits are blanked
//                          (digit 0 is always shown).
// -----------------------------------------------------------------------------
module bcd_scan_counter #(
  parameter int CLK_HZ   = 100000000,
  parameter int TICK_HZ  = 1,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tick,
  output logic                  wrap,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int PRESC_MAX = (CLK_HZ / TICK_HZ) - 1;
  localparam int PRESC_W   = (PRESC_MAX > 0) ? $clog2(PRESC_MAX + 1) : 1;
  localparam int SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W     = 4 * DIGITS;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Non-decimal nibbles are forced to 0 so the count always stays valid BCD.
  function automatic logic [3:0] bcd_sanitize(input logic [3:0] d);
    return (d > 4'd9) ? 4'd0 : d;
  endfunction

  // Active-low {a,b,c,d,e,f,g} pattern for one BCD digit.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               wrap_q,  wrap_d;
  logic [SCAN_W-1:0]  scan_q,  scan_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic [DIGITS-1:0]  an_q,    an_d;
  logic [6:0]         seg_q,   seg_d;

  // ---------------------------------------------------------------------------
  // Prescaler: tick is the terminal-value cycle qualified by en, so a frozen
  // prescaler parked on its terminal value does not keep re-firing.
  // ---------------------------------------------------------------------------
  logic presc_term;

  assign presc_term = (presc_q == PRESC_W'(PRESC_MAX));
  assign tick       = en & presc_term;

  always_comb begin
    presc_d = presc_q;
    if (en) begin
      presc_d = presc_term ? '0 : presc_q + PRESC_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // BCD count. The unit step enters digit 0 and ripples as long as digits
  // roll over; if it falls out of the top digit the whole value has wrapped.
  // A load swallows a coincident tick entirely, including its wrap.
  // ---------------------------------------------------------------------------
  logic       ripple;
  logic [3:0] dig_cur;
  logic [3:0] dig_nxt;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    ripple  = 1'b0;
    dig_cur = 4'd0;
    dig_nxt = 4'd0;

    if (load) begin
      for (int i = 0; i < DIGITS; i++) begin
        count_d[4*i +: 4] = bcd_sanitize(load_val[4*i +: 4]);
      end
    end else if (tick) begin
      ripple = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
        dig_cur = count_q[4*i +: 4];
        dig_nxt = dig_cur;
        if (ripple) begin
          if (up_dn) begin
            if (dig_cur == 4'd9) begin
              dig_nxt = 4'd0;
              ripple  = 1'b1;
            end else begin
              dig_nxt = dig_cur + 4'd1;
              ripple  = 1'b0;
            end
          end else begin
            if (dig_cur == 4'd0) begin
              dig_nxt = 4'd9;
              ripple  = 1'b1;
            end else begin
              dig_nxt = dig_cur - 4'd1;
              ripple  = 1'b0;
            end
          end
        end
        count_d[4*i +: 4] = dig_nxt;
      end
      wrap_d = ripple;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan divider and digit index; free-running, independent of en.
  // ---------------------------------------------------------------------------
  logic scan_term;

  assign scan_term = (scan_q == SCAN_W'(SCAN_DIV - 1));

  always_comb begin
    scan_d = scan_term ? '0 : scan_q + SCAN_W'(1);
    idx_d  = idx_q;
    if (scan_term) begin
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Display stage: an and seg are registered together from the same index.
  // ---------------------------------------------------------------------------
  logic [3:0] disp_digit;
`ifdef LEADING_ZERO_BLANK_EN
  logic       disp_blank;
  logic       zero_above;
`endif

  always_comb begin
    disp_digit = 4'd0;
`ifdef LEADING_ZERO_BLANK_EN
    disp_blank = 1'b0;
    zero_above = 1'b1;
    // Walk from the most-significant digit down; a digit is a leading zero
    // when it and everything above it are zero.
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above & (count_q[4*i +: 4] == 4'd0);
      if (idx_q == IDX_W'(i)) begin
        disp_blank = zero_above & (i != 0);
      end
    end
`endif
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        disp_digit = count_q[4*i +: 4];
      end
    end

    an_d  = ~(DIGITS'(1) << idx_q);
    seg_d = seg_decode(disp_digit);
`ifdef LEADING_ZERO_BLANK_EN
    if (disp_blank) begin
      seg_d = 7'b1111111;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Register stage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      presc_q <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
      scan_q  <= '0;
      idx_q   <= '0;
      an_q    <= '1;
      seg_q   <= 7'b1111111;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign an    = an_q;
  assign seg   = seg_q;

endmodule
